// File: rtl/axi_read_master_ctrl.sv
// AXI4 read master control: issues one AR burst per start_read request,
// streams accepted R beats into a data buffer and reports completion with
// a sticky response/protocol error flag.
module axi_read_master_ctrl #(
    parameter int C_M_AXI_ADDR_WIDTH = 8,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                          AXI_aclk,
    input  logic                          AXI_aresetn,
    input  logic                          start_read,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] src_addr,
    input  logic [1:0]                    burst_type,
    input  logic [2:0]                    burst_size,
    input  logic [8:0]                    beats,
    output logic                          read_transaction_completed,
    output logic                          read_resp_error,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_araddr,
    output logic [7:0]                    M_AXI_arlen,
    output logic [2:0]                    M_AXI_arsize,
    output logic [1:0]                    M_AXI_arburst,
    output logic                          M_AXI_arvalid,
    input  logic                          M_AXI_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_rdata,
    input  logic [1:0]                    M_AXI_rresp,
    input  logic                          M_AXI_rlast,
    input  logic                          M_AXI_rvalid,
    output logic                          M_AXI_rready,
    output logic                          buf_wr_en,
    output logic [C_M_AXI_DATA_WIDTH-1:0] buf_wr_data,
    input  logic                          buf_full
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]                      arlen_q;
    logic [2:0]                      size_q;
    logic [1:0]                      burst_q;
    logic [8:0]                      beats_q;
    logic [8:0]                      cnt_q;
    logic                            arvalid_q;
    logic                            err_q, err_d;
    logic                            done_q;
    logic                            rerr_q;
    logic                            accept;
    logic                            rready;
    logic                            r_hs;
    logic                            last_beat;
    logic                            unused_rresp0;

    // Only OKAY/EXOKAY differ in bit 0; errors are flagged on bit 1 alone.
    assign unused_rresp0 = M_AXI_rresp[0];

    // A request arriving while the completion pulse is out is dropped.
    assign accept    = (state_q == IDLE) && start_read && !done_q;
    assign rready    = (state_q == DATA) && !buf_full;
    assign r_hs      = rready && M_AXI_rvalid;
    assign last_beat = (cnt_q == beats_q - 9'd1);

    // State register.
    always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
        if (!AXI_aresetn) state_q <= IDLE;
        else              state_q <= state_d;
    end

    // Next state and sticky error; rlast disagreeing with the beat count is
    // a protocol error but still ends the burst.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (accept) state_d = (beats != 9'd0) ? ADDR : DONE;
            end
            ADDR: if (arvalid_q && M_AXI_arready) state_d = DATA;
            DATA: begin
                if (r_hs) begin
                    if (M_AXI_rresp[1] || (M_AXI_rlast != last_beat)) err_d = 1'b1;
                    if (M_AXI_rlast || last_beat) state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, beat counter, registered arvalid and registered done/error
    // (the pulse is launched from DONE and seen the cycle after).
    always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
        if (!AXI_aresetn) begin
            addr_q    <= '0;
            arlen_q   <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beats_q   <= '0;
            cnt_q     <= '0;
            arvalid_q <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= src_addr;
                arlen_q <= beats[7:0] - 8'd1;
                size_q  <= burst_size;
                burst_q <= burst_type;
                beats_q <= beats;
                cnt_q   <= '0;
            end else if (r_hs) begin
                cnt_q   <= cnt_q + 9'd1;
            end
            arvalid_q <= (state_d == ADDR);
            err_q     <= err_d;
            done_q    <= (state_q == DONE);
            rerr_q    <= (state_q == DONE) && err_q;
        end
    end

    assign M_AXI_araddr               = addr_q;
    assign M_AXI_arlen                = arlen_q;
    assign M_AXI_arsize               = size_q;
    assign M_AXI_arburst              = burst_q;
    assign M_AXI_arvalid              = arvalid_q;
    assign M_AXI_rready               = rready;
    assign buf_wr_en                  = r_hs;
    assign buf_wr_data                = r_hs ? M_AXI_rdata : '0;
    assign read_transaction_completed = done_q;
    assign read_resp_error            = rerr_q;

endmodule

// File: tb/tb_axi_read_master_ctrl.sv
// Testbench for axi_read_master_ctrl: AXI slave responder, negedge monitor
// and per-scenario tasks checked against a transaction-level model.
module tb_axi_read_master_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start_read = 1'b0;
    logic [7:0]  src_addr = '0;
    logic [1:0]  burst_type = '0;
    logic [2:0]  burst_size = '0;
    logic [8:0]  beats = '0;
    logic        done, rerr;
    logic [7:0]  araddr, arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0, rvalid = 1'b0, rready;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        buf_full = 1'b0;

    axi_read_master_ctrl #(.C_M_AXI_ADDR_WIDTH(8), .C_M_AXI_DATA_WIDTH(32)) dut (
        .AXI_aclk(clk), .AXI_aresetn(rstn), .start_read(start_read),
        .src_addr(src_addr), .burst_type(burst_type), .burst_size(burst_size),
        .beats(beats), .read_transaction_completed(done), .read_resp_error(rerr),
        .M_AXI_araddr(araddr), .M_AXI_arlen(arlen), .M_AXI_arsize(arsize),
        .M_AXI_arburst(arburst), .M_AXI_arvalid(arvalid), .M_AXI_arready(arready),
        .M_AXI_rdata(rdata), .M_AXI_rresp(rresp), .M_AXI_rlast(rlast),
        .M_AXI_rvalid(rvalid), .M_AXI_rready(rready),
        .buf_wr_en(wr_en), .buf_wr_data(wr_data), .buf_full(buf_full));

    always #5 clk = ~clk;

    int pass = 0, total = 0, cyc = 0;
    always @(posedge clk) cyc++;

    // slave configuration and state
    int ar_delay = 0, rlast_at = 0, err_idx = -1, ar_wait = 0;
    int s_idx = 0, s_n = 0;
    bit s_pend = 0, rnd_full = 0;
    logic [31:0] data_arr [256];

    // monitor results
    bit ar_hs_f = 0, r_hs_f = 0, prev_pend = 0;
    logic [20:0] prev_fields;
    int ar_count, wr_count, done_count, done_cyc, stable_viol, full_viol, wen_viol;
    logic done_err;
    logic [7:0] cap_addr, cap_len;
    logic [2:0] cap_size;
    logic [1:0] cap_burst;
    logic [31:0] got [$];

    // Monitor: everything is stable at negedge, so what is seen here is what
    // the DUT commits at the following rising edge.
    always @(negedge clk) begin
        ar_hs_f = arvalid && arready;
        r_hs_f  = rvalid && rready;
        if (prev_pend && (!arvalid || {araddr, arlen, arsize, arburst} !== prev_fields))
            stable_viol++;
        prev_pend   = arvalid && !arready;
        prev_fields = {araddr, arlen, arsize, arburst};
        if (ar_hs_f) begin
            ar_count++;
            cap_addr = araddr; cap_len = arlen; cap_size = arsize; cap_burst = arburst;
        end
        if (wr_en !== r_hs_f) wen_viol++;
        if (r_hs_f) begin got.push_back(wr_data); wr_count++; end
        if (buf_full && rready) full_viol++;
        if (done) begin done_count++; done_cyc = cyc; done_err = rerr; end
    end

    // AXI slave: drives AR ready and R beats just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (!rstn) s_pend = 0;
        else if (ar_hs_f) begin
            s_pend = 1; s_idx = 0;
            s_n = (rlast_at > 0) ? rlast_at : int'(cap_len) + 1;
        end else if (r_hs_f && s_pend) begin
            s_idx++;
            if (s_idx >= s_n) s_pend = 0;
        end
        if (arvalid) begin arready = (ar_wait >= ar_delay); ar_wait++; end
        else begin arready = 1'b0; ar_wait = 0; end
        rvalid = s_pend;
        rdata  = s_pend ? data_arr[s_idx] : 32'h0;
        rresp  = (s_pend && s_idx == err_idx) ? 2'b10 : 2'b00;
        rlast  = s_pend && (s_idx == s_n - 1);
        if (rnd_full) buf_full = ($urandom_range(0, 3) == 0);
    end

    task automatic clr(input int ard, input int rla, input int eidx);
        ar_delay = ard; rlast_at = rla; err_idx = eidx;
        ar_count = 0; wr_count = 0; done_count = 0; done_cyc = -1; done_err = 1'bx;
        stable_viol = 0; full_viol = 0; wen_viol = 0; got.delete();
        for (int i = 0; i < 256; i++) data_arr[i] = $urandom;
    endtask

    task automatic go(input [7:0] a, input [1:0] bt, input [2:0] bs, input [8:0] b, output int n);
        @(posedge clk); #1;
        src_addr = a; burst_type = bt; burst_size = bs; beats = b; start_read = 1'b1; n = cyc;
        @(posedge clk); #1;
        start_read = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string nm);
        for (int i = 0; i < budget && done_count == 0; i++) @(posedge clk);
        @(posedge clk); #1;
        total++;
        if (done_count == 0) $display("FAIL %s: no done pulse within %0d cycles", nm, budget);
        else pass++;
    endtask

    task automatic test_reset;
        #1;
        total++;
        if ({arvalid, rready, wr_en, done, rerr} !== 5'b0)
            $display("FAIL reset_ctl: got %b want 00000", {arvalid, rready, wr_en, done, rerr});
        else pass++;
        total++;
        if ({araddr, arlen, arsize, arburst} !== 21'h0)
            $display("FAIL reset_ar: got %h want 0", {araddr, arlen, arsize, arburst});
        else pass++;
        #22 rstn = 1'b1;
    endtask

    task automatic test_basic;
        int n;
        clr(0, 0, -1);
        go(8'h10, 2'b01, 3'd2, 9'd4, n);
        wait_done(30, "basic_done");
        total++; if (arlen !== 8'd3) $display("FAIL basic_arlen: got %0d want 3", arlen); else pass++;
        total++;
        if ({cap_addr, cap_size, cap_burst} !== {8'h10, 3'd2, 2'b01})
            $display("FAIL basic_ar: got %h want %h", {cap_addr, cap_size, cap_burst}, {8'h10, 3'd2, 2'b01});
        else pass++;
        total++; if (wr_count != 4) $display("FAIL basic_writes: got %0d want 4", wr_count); else pass++;
        for (int i = 0; i < wr_count && i < 4; i++) begin
            total++;
            if (got[i] !== data_arr[i]) $display("FAIL basic_data%0d: got %h want %h", i, got[i], data_arr[i]);
            else pass++;
        end
        total++; if (done_cyc != n + 7) $display("FAIL basic_latency: got %0d want %0d", done_cyc - n, 7); else pass++;
        total++; if (done_err !== 1'b0) $display("FAIL basic_err: got %b want 0", done_err); else pass++;
        total++; if (wen_viol != 0) $display("FAIL basic_wren: got %0d want 0", wen_viol); else pass++;
    endtask

    task automatic test_ar_delay;
        int n;
        clr(5, 0, -1);
        go(8'hA4, 2'b01, 3'd1, 9'd3, n);
        wait_done(40, "ardly_done");
        total++; if (stable_viol != 0) $display("FAIL ardly_stable: got %0d want 0", stable_viol); else pass++;
        total++; if (ar_count != 1) $display("FAIL ardly_hs: got %0d want 1", ar_count); else pass++;
        total++; if (done_cyc != n + 11) $display("FAIL ardly_latency: got %0d want 11", done_cyc - n); else pass++;
        total++; if (wr_count != 3) $display("FAIL ardly_writes: got %0d want 3", wr_count); else pass++;
    endtask

    task automatic test_buf_full;
        int n;
        clr(0, 0, -1);
        go(8'h40, 2'b01, 3'd2, 9'd8, n);
        for (int i = 0; i < 20 && wr_count < 2; i++) begin @(posedge clk); #1; end
        buf_full = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        buf_full = 1'b0;
        wait_done(40, "full_done");
        total++; if (full_viol != 0) $display("FAIL full_rready: got %0d want 0", full_viol); else pass++;
        total++; if (wr_count != 8) $display("FAIL full_writes: got %0d want 8", wr_count); else pass++;
        for (int i = 0; i < wr_count && i < 8; i++) begin
            total++;
            if (got[i] !== data_arr[i]) $display("FAIL full_data%0d: got %h want %h", i, got[i], data_arr[i]);
            else pass++;
        end
        total++; if (done_cyc != n + 14) $display("FAIL full_latency: got %0d want 14", done_cyc - n); else pass++;
        total++; if (done_err !== 1'b0) $display("FAIL full_err: got %b want 0", done_err); else pass++;
    endtask

    task automatic test_rresp_err;
        int n;
        clr(0, 0, 1);
        go(8'h08, 2'b01, 3'd2, 9'd4, n);
        wait_done(30, "rresp_done");
        total++; if (wr_count != 4) $display("FAIL rresp_writes: got %0d want 4", wr_count); else pass++;
        total++; if (done_err !== 1'b1) $display("FAIL rresp_err: got %b want 1", done_err); else pass++;
    endtask

    task automatic test_early_rlast;
        int n;
        clr(0, 2, -1);
        go(8'h30, 2'b01, 3'd2, 9'd4, n);
        wait_done(30, "early_done");
        total++; if (wr_count != 2) $display("FAIL early_writes: got %0d want 2", wr_count); else pass++;
        total++; if (done_cyc != n + 5) $display("FAIL early_latency: got %0d want 5", done_cyc - n); else pass++;
        total++; if (done_err !== 1'b1) $display("FAIL early_err: got %b want 1", done_err); else pass++;
        clr(0, 0, -1);
        go(8'h55, 2'b00, 3'd0, 9'd0, n);
        wait_done(20, "zero_done");
        total++; if (ar_count != 0) $display("FAIL zero_ar: got %0d want 0", ar_count); else pass++;
        total++; if (done_cyc != n + 2) $display("FAIL zero_latency: got %0d want 2", done_cyc - n); else pass++;
        total++; if (done_err !== 1'b0) $display("FAIL zero_err: got %b want 0", done_err); else pass++;
    endtask

    task automatic test_back_to_back;
        int n;
        clr(0, 0, -1);
        go(8'h20, 2'b01, 3'd2, 9'd4, n);
        @(posedge clk); #1;
        src_addr = 8'h99; beats = 9'd2; start_read = 1'b1;
        @(posedge clk); #1;
        start_read = 1'b0;
        for (int i = 0; i < 20 && cyc < n + 7; i++) begin @(posedge clk); #1; end
        src_addr = 8'h77; beats = 9'd1; start_read = 1'b1;
        @(posedge clk); #1;
        start_read = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        total++; if (done_count != 1) $display("FAIL b2b_dones: got %0d want 1", done_count); else pass++;
        total++; if (ar_count != 1) $display("FAIL b2b_ar: got %0d want 1", ar_count); else pass++;
        total++; if (wr_count != 4) $display("FAIL b2b_writes: got %0d want 4", wr_count); else pass++;
        total++; if (araddr !== 8'h20) $display("FAIL b2b_latched: got %h want 20", araddr); else pass++;
        clr(0, 0, -1);
        go(8'h60, 2'b01, 3'd2, 9'd2, n);
        wait_done(20, "b2b_next_done");
        total++; if (done_cyc != n + 5) $display("FAIL b2b_next_latency: got %0d want 5", done_cyc - n); else pass++;
    endtask

    task automatic test_reset_mid;
        int n;
        clr(0, 0, -1);
        go(8'h70, 2'b01, 3'd2, 9'd8, n);
        repeat (3) @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        total++;
        if ({arvalid, rready, wr_en, done, rerr, araddr, arlen} !== 21'h0)
            $display("FAIL rstmid_outs: got %h want 0", {arvalid, rready, wr_en, done, rerr, araddr, arlen});
        else pass++;
        repeat (3) @(posedge clk);
        #3 rstn = 1'b1;
        total++; if (done_count != 0) $display("FAIL rstmid_nodone: got %0d want 0", done_count); else pass++;
        clr(0, 0, -1);
        go(8'h12, 2'b01, 3'd2, 9'd1, n);
        wait_done(20, "rstmid_done");
        total++; if (done_cyc != n + 4) $display("FAIL rstmid_latency: got %0d want 4", done_cyc - n); else pass++;
        total++; if (wr_count != 1 || done_err !== 1'b0)
            $display("FAIL rstmid_result: got writes %0d err %b want 1 0", wr_count, done_err);
        else pass++;
    endtask

    task automatic test_random;
        int n, b, e;
        logic [7:0] a;
        for (int t = 0; t < 12; t++) begin
            b = $urandom_range(1, 16);
            a = 8'($urandom);
            e = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, b - 1)) : -1;
            clr($urandom_range(0, 3), 0, e);
            rnd_full = 1;
            go(a, 2'($urandom_range(0, 2)), 3'($urandom_range(0, 2)), 9'(b), n);
            wait_done(200, "rnd_done");
            rnd_full = 0; buf_full = 1'b0;
            total++;
            if (cap_addr !== a || cap_len !== 8'(b - 1))
                $display("FAIL rnd_ar%0d: got %h/%0d want %h/%0d", t, cap_addr, cap_len, a, b - 1);
            else pass++;
            total++;
            if (wr_count != b) $display("FAIL rnd_writes%0d: got %0d want %0d", t, wr_count, b); else pass++;
            for (int i = 0; i < wr_count && i < b; i++) begin
                total++;
                if (got[i] !== data_arr[i]) $display("FAIL rnd_data%0d_%0d: got %h want %h", t, i, got[i], data_arr[i]);
                else pass++;
            end
            total++;
            if (done_err !== (e >= 0)) $display("FAIL rnd_err%0d: got %b want %b", t, done_err, e >= 0); else pass++;
            total++;
            if (full_viol + stable_viol + wen_viol != 0)
                $display("FAIL rnd_proto%0d: got full %0d stable %0d wren %0d want 0", t, full_viol, stable_viol, wen_viol);
            else pass++;
            repeat (2) @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ar_delay();
        test_buf_full();
        test_rresp_err();
        test_early_rlast();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule

// File: doc/axi_read_master_ctrl.md
AXI_READ_MASTER_CTRL -- requirements
Module: axi_read_master_ctrl

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 8: AXI read address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32: AXI read data and buffer data width.
REQ-003 SHALL have port AXI_aclk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port AXI_aresetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start_read  input  1  single-cycle request pulse from the read channel FSM.
REQ-006 SHALL have port src_addr  input  C_M_AXI_ADDR_WIDTH  burst start address.
REQ-007 SHALL have port burst_type  input  2  AXI burst type.
REQ-008 SHALL have port burst_size  input  3  AXI burst size.
REQ-009 SHALL have port beats  input  9  burst length in beats (1..256).
REQ-010 SHALL have port read_transaction_completed  output  1  single-cycle done pulse.
REQ-011 SHALL have port read_resp_error  output  1  error status, valid with the done pulse.
REQ-012 SHALL have ports M_AXI_araddr/arlen[8]/arsize[3]/arburst[2]/arvalid  output, and M_AXI_arready  input: AXI4 AR channel.
REQ-013 SHALL have ports M_AXI_rdata[C_M_AXI_DATA_WIDTH]/rresp[2]/rlast/rvalid  input, and M_AXI_rready  output: AXI4 R channel.
REQ-014 SHALL have ports buf_wr_en  output  1, buf_wr_data  output  C_M_AXI_DATA_WIDTH, and buf_full  input  1: data buffer write port.

Function
REQ-015 SHALL implement the FSM states IDLE, ADDR, DATA and DONE.
REQ-016 In IDLE, start_read SHALL latch src_addr, burst_type, burst_size and beats, and SHALL move to ADDR when beats != 0 or to DONE when beats == 0.
REQ-017 start_read SHALL be ignored in every state other than IDLE, and the latched values SHALL NOT change.
REQ-018 M_AXI_arvalid SHALL be registered and SHALL assert in the cycle after start_read (in ADDR).
REQ-019 While M_AXI_arvalid is high, the AR outputs SHALL stay stable until M_AXI_arready is sampled high.
REQ-020 AR fields SHALL be: araddr = latched src_addr; arlen = beats-1 (8 bits); arsize = burst_size; arburst = burst_type.
REQ-021 On the AR handshake, M_AXI_arvalid SHALL deassert on the next edge and the FSM SHALL enter DATA.
REQ-022 In DATA, M_AXI_rready SHALL equal !buf_full; in all other states it SHALL be 0.
REQ-023 Each R handshake SHALL drive buf_wr_en = 1 and buf_wr_data = M_AXI_rdata combinationally in the same cycle, and SHALL increment a 9-bit beat counter.
REQ-024 When buf_full is high, no beat SHALL be accepted and the beat counter SHALL hold.
REQ-025 An R handshake with M_AXI_rresp[1] = 1 (SLVERR or DECERR) SHALL set a sticky error flag.
REQ-026 Leaving DATA:
- Normal: rlast accepted with counter == beats-1 → DONE.
- Early rlast (counter < beats-1) → set error, go to DONE.
- Counter reaches beats-1 on a beat without rlast → set error, go to DONE.
- In every exit case, rready SHALL deassert on the next edge.
REQ-027 In DONE, read_transaction_completed SHALL be high for exactly one cycle, with read_resp_error equal to the sticky flag.
REQ-028 In the cycle after DONE, the FSM SHALL return to IDLE and the sticky flag SHALL clear.
REQ-029 Minimum latency, with arready and rvalid always high: start_read at cycle N → completion pulse at N+3+beats.
REQ-030 A start_read in the same cycle that the done pulse is high SHALL be ignored; the next request SHALL be accepted in IDLE.

Reset
REQ-031 During reset (asynchronous, active-low) the block SHALL go to IDLE and hold: arvalid = 0, rready = 0, buf_wr_en = 0, read_transaction_completed = 0, read_resp_error = 0, AR fields = 0, beat counter = 0, latched registers = 0.
REQ-032 Reset asserted mid-burst SHALL abort the transaction with no done pulse; after release, the block SHALL accept a new start_read.

Verification
REQ-033 Bench: beats=4, addr=0x10, INCR, size=2, arready/rvalid always 1 → arlen=3, 4 buf writes, done pulse at N+7, error=0.
REQ-034 Bench: arready delayed 5 cycles → AR fields stable throughout, and exactly one AR handshake.
REQ-035 Bench: buf_full high for 3 cycles mid-burst of 8 → rready low for those cycles, 8 writes total, no lost beats.
REQ-036 Bench: rresp=2'b10 on beat 2 of 4 → all 4 beats written, done with read_resp_error=1.
REQ-037 Bench: rlast on beat 2 of 4 → DONE after beat 2 with error=1; also beats=0 → no AR, done pulse at N+2, error=0.
REQ-038 Bench: reset asserted during DATA → all outputs go to 0 immediately, no done pulse; a following beats=1 request completes normally.
